// File: rtl/regfile_bridge_pkg.sv
// Shared types for the regfile request bridge: FSM state encoding and
// request/response records at the default port widths.
`timescale 1ns/1ps
package regfile_bridge_pkg;

  localparam int unsigned BRIDGE_AW = 8;
  localparam int unsigned BRIDGE_DW = 8;

  // Legacy state codes kept visible so old waveforms/decoders still line up
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    WR   = S_WR,
    RD   = S_RD,
    RESP = S_RESP
  } state_e;

  typedef struct packed {
    logic                 write;
    logic [BRIDGE_AW-1:0] addr;
    logic [BRIDGE_DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic                 write;
    logic                 err;
    logic [BRIDGE_DW-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/regfile_req_bridge.sv
// Single-outstanding bridge from a valid/ready request channel to regfile
// ren/wen strobes, with a valid/ready response and a completion counter.
`timescale 1ns/1ps
module regfile_req_bridge
  import regfile_bridge_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int NUM_REGS   = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_write,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_din,
  output logic          rf_ren,
  output logic          rf_wen,
  input  logic [DW-1:0] rf_dout,
  output logic [15:0]   txn_count
);

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  if (NUM_REGS < 1 || NUM_REGS > (2 ** AW)) begin : g_bad_num_regs
    $error("regfile_req_bridge: NUM_REGS must be in 1..2**AW");
  end
  if (RD_LATENCY < 0 || RD_LATENCY > 7) begin : g_bad_rd_latency
    $error("regfile_req_bridge: RD_LATENCY must be in 0..7");
  end

  state_e     state;
  logic [2:0] lat_cnt;
  logic       addr_err;

  assign addr_err  = 32'(req_addr) >= 32'(NUM_REGS);

  // Strobes decode straight from state so an async reset drops them at once
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rf_wen    = (state == WR);
  assign rf_ren    = (state == RD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      rf_addr   <= '0;
      rf_din    <= '0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      txn_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_write <= req_write;
            rsp_err   <= addr_err;
            rsp_rdata <= '0;
            lat_cnt   <= '0;
            if (addr_err) begin
              state <= RESP;
            end else begin
              rf_addr <= req_addr;
              if (req_write) begin
                rf_din <= req_wdata;
                state  <= WR;
              end else begin
                state  <= RD;
              end
            end
          end
        end
        WR: state <= RESP;
        RD: begin
          if (lat_cnt == LAT) begin
            rsp_rdata <= rf_dout;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            txn_count <= txn_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_strobe_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(rf_ren && rf_wen));

endmodule

// File: tb/tb_regfile_req_bridge.sv
// Directed bench: four bridge instances (RD_LATENCY 1/0/3, NUM_REGS 4),
// each driving its own behavioural regfile; one instance is selected at a time.
`timescale 1ns/1ps
module tb_regfile_req_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         sel;
  logic       req_valid, req_write, rsp_ready;
  logic [7:0] req_addr, req_wdata;

  logic       req_valid_a [4];
  logic       rsp_ready_a [4];
  logic       req_ready_a [4];
  logic       rsp_valid_a [4];
  logic       rsp_write_a [4];
  logic       rsp_err_a   [4];
  logic       rf_ren_a    [4];
  logic       rf_wen_a    [4];
  logic [7:0] rsp_rdata_a [4];
  logic [7:0] rf_addr_a   [4];
  logic [7:0] rf_din_a    [4];
  logic [7:0] rf_dout_a   [4];
  logic [15:0] txn_a      [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_valid_a[i] = (sel == i) && req_valid;
      rsp_ready_a[i] = (sel == i) && rsp_ready;
    end
  end

  logic        cur_req_ready, cur_rsp_valid, cur_rsp_write, cur_rsp_err, cur_rf_ren, cur_rf_wen;
  logic [7:0]  cur_rsp_rdata, cur_rf_addr, cur_rf_din;
  logic [15:0] cur_txn;
  assign cur_req_ready = req_ready_a[sel];
  assign cur_rsp_valid = rsp_valid_a[sel];
  assign cur_rsp_write = rsp_write_a[sel];
  assign cur_rsp_err   = rsp_err_a[sel];
  assign cur_rf_ren    = rf_ren_a[sel];
  assign cur_rf_wen    = rf_wen_a[sel];
  assign cur_rsp_rdata = rsp_rdata_a[sel];
  assign cur_rf_addr   = rf_addr_a[sel];
  assign cur_rf_din    = rf_din_a[sel];
  assign cur_txn       = txn_a[sel];

  // Behavioural regfiles: write on wen, read data delayed through a pipe
  logic [7:0] mem  [4][256];
  logic [7:0] pipe [4][4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rf_wen_a[i]) mem[i][rf_addr_a[i]] <= rf_din_a[i];
      pipe[i][0] <= mem[i][rf_addr_a[i]];
      for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
    end
  end
  assign rf_dout_a[0] = pipe[0][0];
  assign rf_dout_a[1] = mem[1][rf_addr_a[1]];
  assign rf_dout_a[2] = pipe[2][2];
  assign rf_dout_a[3] = pipe[3][0];

  regfile_req_bridge #(.AW(8), .DW(8), .NUM_REGS(256), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready_a[0]), .rsp_write(rsp_write_a[0]),
    .rsp_err(rsp_err_a[0]), .rsp_rdata(rsp_rdata_a[0]), .rf_addr(rf_addr_a[0]),
    .rf_din(rf_din_a[0]), .rf_ren(rf_ren_a[0]), .rf_wen(rf_wen_a[0]),
    .rf_dout(rf_dout_a[0]), .txn_count(txn_a[0]));

  regfile_req_bridge #(.AW(8), .DW(8), .NUM_REGS(256), .RD_LATENCY(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready_a[1]), .rsp_write(rsp_write_a[1]),
    .rsp_err(rsp_err_a[1]), .rsp_rdata(rsp_rdata_a[1]), .rf_addr(rf_addr_a[1]),
    .rf_din(rf_din_a[1]), .rf_ren(rf_ren_a[1]), .rf_wen(rf_wen_a[1]),
    .rf_dout(rf_dout_a[1]), .txn_count(txn_a[1]));

  regfile_req_bridge #(.AW(8), .DW(8), .NUM_REGS(256), .RD_LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a[2]), .rsp_ready(rsp_ready_a[2]), .rsp_write(rsp_write_a[2]),
    .rsp_err(rsp_err_a[2]), .rsp_rdata(rsp_rdata_a[2]), .rf_addr(rf_addr_a[2]),
    .rf_din(rf_din_a[2]), .rf_ren(rf_ren_a[2]), .rf_wen(rf_wen_a[2]),
    .rf_dout(rf_dout_a[2]), .txn_count(txn_a[2]));

  regfile_req_bridge #(.AW(8), .DW(8), .NUM_REGS(4), .RD_LATENCY(1)) u_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a[3]), .req_ready(req_ready_a[3]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a[3]), .rsp_ready(rsp_ready_a[3]), .rsp_write(rsp_write_a[3]),
    .rsp_err(rsp_err_a[3]), .rsp_rdata(rsp_rdata_a[3]), .rf_addr(rf_addr_a[3]),
    .rf_din(rf_din_a[3]), .rf_ren(rf_ren_a[3]), .rf_wen(rf_wen_a[3]),
    .rf_dout(rf_dout_a[3]), .txn_count(txn_a[3]));

  int n_tests = 0;
  int n_fail  = 0;

  // Results of the last run_txn call
  logic [7:0] r_rdata, r_wen_addr, r_wen_din;
  logic       r_err, r_write, r_both, r_ren_addr_bad;
  int         r_lat, r_wen_n, r_ren_n;

  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 8'hEE; req_wdata = 8'hEE; req_write = ~wr;
    r_lat = 1; r_wen_n = 0; r_ren_n = 0; r_both = 1'b0; r_ren_addr_bad = 1'b0;
    r_wen_addr = 8'h00; r_wen_din = 8'h00;
    forever begin
      if (cur_rf_wen) begin r_wen_n++; r_wen_addr = cur_rf_addr; r_wen_din = cur_rf_din; end
      if (cur_rf_ren) begin r_ren_n++; if (cur_rf_addr !== addr) r_ren_addr_bad = 1'b1; end
      if (cur_rf_wen && cur_rf_ren) r_both = 1'b1;
      if (cur_rsp_valid || r_lat >= 40) break;
      @(negedge clk);
      r_lat++;
    end
    r_rdata = cur_rsp_rdata; r_err = cur_rsp_err; r_write = cur_rsp_write;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (req_ready_a[i] !== 1'b1 || rsp_valid_a[i] !== 1'b0 || rf_ren_a[i] !== 1'b0 ||
          rf_wen_a[i] !== 1'b0 || rsp_err_a[i] !== 1'b0 || rsp_rdata_a[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: ready=%b valid=%b ren=%b wen=%b err=%b rdata=%h, expected 1 0 0 0 0 00",
                 i, req_ready_a[i], rsp_valid_a[i], rf_ren_a[i], rf_wen_a[i], rsp_err_a[i], rsp_rdata_a[i]);
      end
      n_tests++;
      if (txn_a[i] !== 16'd0) begin
        n_fail++; $display("FAIL reset_txn[%0d]: got %0d expected 0", i, txn_a[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    logic [15:0] t0;
    sel = 0; t0 = cur_txn;
    run_txn(1'b1, 8'h03, 8'h06);
    n_tests++;
    if (r_lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected 2", r_lat); end
    n_tests++;
    if (r_wen_n !== 1 || r_ren_n !== 0) begin
      n_fail++; $display("FAIL wr_strobes: wen=%0d ren=%0d expected 1 0", r_wen_n, r_ren_n);
    end
    n_tests++;
    if (r_wen_addr !== 8'h03 || r_wen_din !== 8'h06) begin
      n_fail++; $display("FAIL wr_addr_din: got %h/%h expected 03/06", r_wen_addr, r_wen_din);
    end
    n_tests++;
    if (r_write !== 1'b1 || r_err !== 1'b0 || r_rdata !== 8'h00) begin
      n_fail++; $display("FAIL wr_rsp: write=%b err=%b rdata=%h expected 1 0 00", r_write, r_err, r_rdata);
    end
    n_tests++;
    if (r_both !== 1'b0) begin n_fail++; $display("FAIL wr_both_strobes: got %b expected 0", r_both); end
    n_tests++;
    if (cur_txn !== t0 + 16'd1) begin
      n_fail++; $display("FAIL wr_txn: got %0d expected %0d", cur_txn, t0 + 16'd1);
    end
    n_tests++;
    if (cur_rsp_valid !== 1'b0 || cur_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_back_idle: valid=%b ready=%b expected 0 1", cur_rsp_valid, cur_req_ready);
    end
  endtask

  task automatic test_read_latency(input int s, input int lat);
    logic [7:0] exp_data;
    sel = s;
    for (int i = 0; i < 4; i++) run_txn(1'b1, 8'(i), 8'(i * 2));
    for (int i = 0; i < 4; i++) begin
      exp_data = 8'(i * 2);
      run_txn(1'b0, 8'(i), 8'h55);
      n_tests++;
      if (r_rdata !== exp_data || r_err !== 1'b0 || r_write !== 1'b0) begin
        n_fail++; $display("FAIL rd_data L%0d a%0d: rdata=%h err=%b write=%b expected %h 0 0",
                           lat, i, r_rdata, r_err, r_write, exp_data);
      end
      n_tests++;
      if (r_lat !== 2 + lat) begin
        n_fail++; $display("FAIL rd_latency L%0d a%0d: got %0d expected %0d", lat, i, r_lat, 2 + lat);
      end
      n_tests++;
      if (r_ren_n !== lat + 1 || r_wen_n !== 0 || r_ren_addr_bad !== 1'b0) begin
        n_fail++; $display("FAIL rd_strobes L%0d a%0d: ren=%0d wen=%0d addr_bad=%b expected %0d 0 0",
                           lat, i, r_ren_n, r_wen_n, r_ren_addr_bad, lat + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] t0;
    int          wait_n;
    sel = 0;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h02; req_wdata = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    wait_n = 0;
    while (!cur_rsp_valid && wait_n < 20) begin @(negedge clk); wait_n++; end
    n_tests++;
    if (cur_rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_rsp_arrives: got %b expected 1", cur_rsp_valid);
    end
    t0 = cur_txn;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h00; req_wdata = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (cur_rsp_valid !== 1'b1 || cur_rsp_rdata !== 8'h04 || cur_rsp_write !== 1'b0 ||
          cur_req_ready !== 1'b0 || cur_rf_wen !== 1'b0 || cur_rf_ren !== 1'b0 || cur_txn !== t0) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: valid=%b rdata=%h write=%b ready=%b wen=%b ren=%b txn=%0d expected 1 04 0 0 0 0 %0d",
                 c, cur_rsp_valid, cur_rsp_rdata, cur_rsp_write, cur_req_ready, cur_rf_wen, cur_rf_ren, cur_txn, t0);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cur_rsp_valid !== 1'b0 || cur_txn !== t0 + 16'd1) begin
      n_fail++; $display("FAIL bp_release: valid=%b txn=%0d expected 0 %0d", cur_rsp_valid, cur_txn, t0 + 16'd1);
    end
    n_tests++;
    if (mem[0][0] !== 8'h00) begin
      n_fail++; $display("FAIL bp_ignored_req: mem[0]=%h expected 00", mem[0][0]);
    end
  endtask

  task automatic test_addr_error();
    logic [15:0] t0;
    sel = 3; t0 = cur_txn;
    run_txn(1'b1, 8'h03, 8'h5A);
    n_tests++;
    if (r_err !== 1'b0 || r_wen_n !== 1) begin
      n_fail++; $display("FAIL err_last_reg_wr: err=%b wen=%0d expected 0 1", r_err, r_wen_n);
    end
    run_txn(1'b0, 8'h10, 8'h00);
    n_tests++;
    if (r_err !== 1'b1 || r_rdata !== 8'h00 || r_write !== 1'b0) begin
      n_fail++; $display("FAIL err_rd_rsp: err=%b rdata=%h write=%b expected 1 00 0", r_err, r_rdata, r_write);
    end
    n_tests++;
    if (r_ren_n !== 0 || r_wen_n !== 0 || r_lat !== 1) begin
      n_fail++; $display("FAIL err_rd_no_access: ren=%0d wen=%0d lat=%0d expected 0 0 1", r_ren_n, r_wen_n, r_lat);
    end
    n_tests++;
    if (cur_rf_addr !== 8'h03) begin
      n_fail++; $display("FAIL err_rf_addr_held: got %h expected 03", cur_rf_addr);
    end
    run_txn(1'b1, 8'h04, 8'h11);
    n_tests++;
    if (r_err !== 1'b1 || r_wen_n !== 0 || r_write !== 1'b1 || r_rdata !== 8'h00) begin
      n_fail++; $display("FAIL err_wr_boundary: err=%b wen=%0d write=%b rdata=%h expected 1 0 1 00",
                         r_err, r_wen_n, r_write, r_rdata);
    end
    run_txn(1'b0, 8'h03, 8'h00);
    n_tests++;
    if (r_err !== 1'b0 || r_rdata !== 8'h5A) begin
      n_fail++; $display("FAIL err_last_reg_rd: err=%b rdata=%h expected 0 5a", r_err, r_rdata);
    end
    n_tests++;
    if (cur_txn !== t0 + 16'd4) begin
      n_fail++; $display("FAIL err_txn: got %0d expected %0d", cur_txn, t0 + 16'd4);
    end
  endtask

  task automatic test_reset_mid_read();
    sel = 2;
    run_txn(1'b1, 8'h01, 8'h77);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h01;
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (cur_rf_ren !== 1'b1) begin n_fail++; $display("FAIL mid_ren_active: got %b expected 1", cur_rf_ren); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (cur_rf_ren !== 1'b0 || cur_rsp_valid !== 1'b0 || cur_req_ready !== 1'b1 || cur_txn !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset_abort: ren=%b valid=%b ready=%b txn=%0d expected 0 0 1 0",
                         cur_rf_ren, cur_rsp_valid, cur_req_ready, cur_txn);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (cur_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp: got %b expected 0", cur_rsp_valid); end
    run_txn(1'b0, 8'h01, 8'h00);
    n_tests++;
    if (r_rdata !== 8'h77 || r_lat !== 5 || r_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_next_read: rdata=%h lat=%0d err=%b expected 77 5 0", r_rdata, r_lat, r_err);
    end
    n_tests++;
    if (cur_txn !== 16'd1) begin n_fail++; $display("FAIL mid_txn_restart: got %0d expected 1", cur_txn); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_latency(0, 1);
    test_read_latency(1, 0);
    test_read_latency(2, 3);
    test_backpressure();
    test_addr_error();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
